mpl_axi_lite_regs: RTL
======================

// Module: mpl_axi_lite_regs
// PURPOSE
//  AXI4-Lite slave register bank that terminates the S00_AXI port of the MPL IP.
//  Serves the BFM master and the PS; holds NUM_REGS 32-bit R/W registers.
//  Exposes register contents and per-register write pulses to the MPL core.
//  One outstanding write and one outstanding read. Write and read paths are independent.
// PARAMETERS
//  C_S_AXI_DATA_WIDTH  32  data bus width; only 32 is supported.
//  C_S_AXI_ADDR_WIDTH  6   byte-address width.
//  NUM_REGS            4   number of mapped registers, 1..2**(ADDR_WIDTH-2).
// PORTS
//  S_AXI_ACLK     in   1       clock, single clock domain.
//  S_AXI_ARESETN  in   1       asynchronous, active-low reset.
//  S_AXI_AWADDR   in   AW      write address.   S_AXI_AWPROT in 3   ignored.
//  S_AXI_AWVALID  in   1       write address valid.   S_AXI_AWREADY out 1   write address ready.
//  S_AXI_WDATA    in   32      write data.   S_AXI_WSTRB in 4   byte enables.
//  S_AXI_WVALID   in   1       write data valid.   S_AXI_WREADY out 1   write data ready.
//  S_AXI_BRESP    out  2       write response.
//  S_AXI_BVALID   out  1       write response valid.   S_AXI_BREADY in 1   write response ready.
//  S_AXI_ARADDR   in   AW      read address.   S_AXI_ARPROT in 3   ignored.
//  S_AXI_ARVALID  in   1       read address valid.   S_AXI_ARREADY out 1   read address ready.
//  S_AXI_RDATA    out  32      read data.   S_AXI_RRESP out 2   read response.
//  S_AXI_RVALID   out  1       read data valid.   S_AXI_RREADY in 1   read data ready.
//  regs_q         out  32*NUM_REGS  flattened registers; reg i is at [32*i+:32].
//  reg_wr_pulse   out  NUM_REGS     one-cycle pulse when reg i is written.
// BEHAVIOUR
//  Reset (async, ARESETN=0): all registers 0; AWREADY, WREADY, ARREADY = 0.
//   BVALID, RVALID, reg_wr_pulse = 0; BRESP, RRESP, RDATA = 0.
//   The first cycle after deassertion: the READYs rise.
//   Reset mid-transaction: the transaction is dropped and nothing is completed.
//  Decode: index = addr[AW-1:2]; addr[1:0] is ignored.
//   index >= NUM_REGS means out of range, answered with SLVERR (2'b10).
//  Write FSM W_IDLE -> W_RESP:
//   In W_IDLE, AWREADY=1 until AW is latched and WREADY=1 until W is latched.
//   AW and W may arrive in either order or in the same cycle.
//   Commit happens in the cycle N where the second of the two handshakes completes:
//    - in range: the register takes the byte lanes whose WSTRB bit is 1 at the edge ending N;
//    - reg_wr_pulse[index]=1 during N+1.
//   Out of range: no register changes and no pulse.
//   N+1: BVALID=1, BRESP = OKAY or SLVERR. Both READYs are 0 while in W_RESP.
//   BVALID and BRESP hold until BREADY. The handshake returns the FSM to W_IDLE.
//   Back-to-back throughput: 1 write per 2 cycles when BREADY is tied high.
//  Read FSM R_IDLE -> R_VALID:
//   In R_IDLE, ARREADY=1. An AR handshake in cycle N gives RVALID=1 at N+1.
//   RDATA is the register value sampled in cycle N, or 0 when out of range.
//   RRESP is OKAY or SLVERR.
//   RDATA and RRESP are stable while RVALID=1 and RREADY=0. ARREADY=0 in R_VALID.
//  Simultaneous write commit and read of the same register in cycle N:
//   the read returns the pre-write value; the next read returns the new value.
//  WSTRB=0: treated as a legal write with no data change, OKAY response, and the pulse still fires.
// STRUCTURE
//  mpl_axi_pkg holds:
//   - RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
//   - ADDR_LSB=2;
//   - the FSM state encodings.
//  Sub-module mpl_axi_wr_chan: AW/W latch plus the write FSM, outputs {commit, index, data, strb}.
//  The register array and the read path stay in the top level.
// TESTING
//  1. Reset at t=0, release on an ACLK edge -> READYs 0 during reset, 1 the cycle after.
//     All reads return 0x00000000 with OKAY.
//  2. Write 0x0101FFFF, 0xabcd0001, 0xdead0011, 0xbeef0011 to 0x0/0x4/0x8/0xC, then read back.
//     -> Data matches, OKAY, and reg_wr_pulse bits 0..3 fire once each.
//  3. W before AW by 3 cycles, and AW before W by 3 cycles, to 0x4 with 0x12345678.
//     -> BVALID exactly 1 cycle after the later handshake; reg1 = 0x12345678.
//  4. reg2 = 0xdead0011, then write 0x000000AB with WSTRB=4'b0001.
//     -> reg2 = 0xdead00AB.
//  5. Write and read to 0x10 (NUM_REGS=4) -> BRESP=RRESP=2'b10 and RDATA=0.
//     No register changes and no pulse.
//  6. Hold BREADY/RREADY low for 5 cycles -> BVALID, RVALID and RDATA are stable.
//     No new AW/AR is accepted. Assert ARESETN=0 mid-hold -> VALIDs drop immediately.

Source files
------------

// File: rtl/mpl_axi_pkg.sv
// mpl_axi_pkg
//   Shared definitions for the MPL AXI4-Lite register bank:
//   - AXI response codes
//   - byte-address to word-index shift
//   - write and read FSM state encodings, which are also exposed on the
//     debug ports of mpl_axi_lite_regs
package mpl_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Registers are 32-bit words, so the low two address bits select a byte
  // inside a word and take no part in the register decode.
  localparam int ADDR_LSB = 2;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_e;

  typedef enum logic {
    R_IDLE  = 1'b0,
    R_VALID = 1'b1
  } rd_state_e;

endpackage

// File: rtl/mpl_axi_lite_if.sv
// mpl_axi_lite_if
//   AXI4-Lite bundle between the BFM master / PS and the MPL register bank.
//   Parameters: ADDR_WIDTH (byte address width), DATA_WIDTH (bus width).
//   Modports:
//     master - drives addresses, write data, valids and response readies
//     slave  - drives address/data readies, responses and read data
//
//   Handshake rule on every channel: a transfer happens on the rising clock
//   edge where VALID and READY are both 1. A source holding VALID keeps its
//   payload stable until that edge; READY may depend combinationally on state
//   but never on the same channel's VALID.
interface mpl_axi_lite_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;

  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;

  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, input  awready,
    output wdata, wstrb, wvalid,    input  wready,
    input  bresp, bvalid,           output bready,
    output araddr, arprot, arvalid, input  arready,
    input  rdata, rresp, rvalid,    output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid,    output wready,
    output bresp, bvalid,           input  bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid,    input  rready
  );

endinterface

// File: rtl/mpl_axi_wr_chan.sv
// mpl_axi_wr_chan
//   AXI4-Lite write channel: latches AW and W independently (either order or
//   together), commits once both are present, then holds the B response
//   until BREADY.
//   Ports:
//     clk, rst_n                      clock, async active-low reset
//     awaddr/awvalid/awready          write address channel
//     wdata/wstrb/wvalid/wready       write data channel
//     bresp/bvalid/bready             write response channel
//     live                            0 during reset and the first cycle after
//     commit, commit_idx,
//     commit_data, commit_strb        one-cycle write request to the register array
//     state_dbg                       current write FSM state
module mpl_axi_wr_chan
  import mpl_axi_pkg::*;
#(
  parameter int  ADDR_WIDTH = 6,
  parameter int  DATA_WIDTH = 32,
  parameter int  NUM_REGS   = 4,
  localparam int IDX_W      = ADDR_WIDTH - ADDR_LSB,
  localparam int STRB_W     = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_W-1:0]     wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  output logic                  live,
  output logic                  commit,
  output logic [IDX_W-1:0]      commit_idx,
  output logic [DATA_WIDTH-1:0] commit_data,
  output logic [STRB_W-1:0]     commit_strb,
  output wr_state_e             state_dbg
);

  wr_state_e             state_q, state_d;
  logic                  live_q;
  logic                  aw_done_q, w_done_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic [1:0]            bresp_q;
  logic                  aw_hs, w_hs;
  logic [ADDR_WIDTH-1:0] addr_sel;
  logic                  in_range;
  logic                  unused_addr_lsb;

  // live_q holds the READYs low through reset and for the first cycle after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= W_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      W_IDLE: begin
        awready = live_q & ~aw_done_q;
        wready  = live_q & ~w_done_q;
        // Commit in the cycle whose edge completes the second handshake.
        commit  = (aw_done_q | (awvalid & awready)) & (w_done_q | (wvalid & wready));
        if (commit) begin
          state_d = W_RESP;
        end
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) begin
          state_d = W_IDLE;
        end
      end
      default: state_d = W_IDLE;
    endcase
  end

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;

  // Whichever half arrives in the commit cycle is taken straight off the bus.
  assign addr_sel    = aw_done_q ? awaddr_q : awaddr;
  assign commit_idx  = addr_sel[ADDR_WIDTH-1:ADDR_LSB];
  assign commit_data = w_done_q ? wdata_q : wdata;
  assign commit_strb = w_done_q ? wstrb_q : wstrb;
  assign in_range    = int'(commit_idx) < NUM_REGS;

  assign unused_addr_lsb = ^addr_sel[ADDR_LSB-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q    <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      live_q <= 1'b1;
      if (commit) begin
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
        bresp_q   <= in_range ? RESP_OKAY : RESP_SLVERR;
      end else begin
        if (aw_hs) begin
          aw_done_q <= 1'b1;
          awaddr_q  <= awaddr;
        end
        if (w_hs) begin
          w_done_q <= 1'b1;
          wdata_q  <= wdata;
          wstrb_q  <= wstrb;
        end
      end
    end
  end

  assign bresp     = bresp_q;
  assign live      = live_q;
  assign state_dbg = state_q;

endmodule

// File: rtl/mpl_axi_lite_regs.sv
// mpl_axi_lite_regs
//   AXI4-Lite slave register bank terminating the S00_AXI port of the MPL IP.
//   NUM_REGS read/write 32-bit registers; one outstanding write and one
//   outstanding read, with independent write and read paths.
//   Ports:
//     S_AXI_ACLK, S_AXI_ARESETN   clock, async active-low reset
//     s_axi                       AXI4-Lite slave bundle (mpl_axi_lite_if.slave)
//     regs_q                      flattened registers, reg i at [32*i +: 32]
//     reg_wr_pulse                one-cycle pulse the cycle after reg i is written
//     wr_state_dbg, rd_state_dbg  write / read FSM state
module mpl_axi_lite_regs
  import mpl_axi_pkg::*;
#(
  parameter int  C_S_AXI_DATA_WIDTH = 32,
  parameter int  C_S_AXI_ADDR_WIDTH = 6,
  parameter int  NUM_REGS           = 4,
  localparam int IDX_W              = C_S_AXI_ADDR_WIDTH - ADDR_LSB,
  localparam int STRB_W             = C_S_AXI_DATA_WIDTH / 8
) (
  input  logic                                   S_AXI_ACLK,
  input  logic                                   S_AXI_ARESETN,
  mpl_axi_lite_if.slave                          s_axi,
  output logic [C_S_AXI_DATA_WIDTH*NUM_REGS-1:0] regs_q,
  output logic [NUM_REGS-1:0]                    reg_wr_pulse,
  output wr_state_e                              wr_state_dbg,
  output rd_state_e                              rd_state_dbg
);

  logic [C_S_AXI_DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                          live;
  logic                          commit;
  logic [IDX_W-1:0]              commit_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] commit_data;
  logic [STRB_W-1:0]             commit_strb;
  logic                          awready, wready, bvalid;
  logic [1:0]                    bresp;

  mpl_axi_wr_chan #(
    .ADDR_WIDTH (C_S_AXI_ADDR_WIDTH),
    .DATA_WIDTH (C_S_AXI_DATA_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_wr_chan (
    .clk         (S_AXI_ACLK),
    .rst_n       (S_AXI_ARESETN),
    .awaddr      (s_axi.awaddr),
    .awvalid     (s_axi.awvalid),
    .awready     (awready),
    .wdata       (s_axi.wdata),
    .wstrb       (s_axi.wstrb),
    .wvalid      (s_axi.wvalid),
    .wready      (wready),
    .bresp       (bresp),
    .bvalid      (bvalid),
    .bready      (s_axi.bready),
    .live        (live),
    .commit      (commit),
    .commit_idx  (commit_idx),
    .commit_data (commit_data),
    .commit_strb (commit_strb),
    .state_dbg   (wr_state_dbg)
  );

  assign s_axi.awready = awready;
  assign s_axi.wready  = wready;
  assign s_axi.bvalid  = bvalid;
  assign s_axi.bresp   = bresp;

  // Register array. Out-of-range indices match no register, so they change
  // nothing and raise no pulse.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      reg_wr_pulse <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_wr_pulse[i] <= commit && (commit_idx == IDX_W'(i));
        if (commit && (commit_idx == IDX_W'(i))) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (commit_strb[b]) begin
              regs[i][8*b +: 8] <= commit_data[8*b +: 8];
            end
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign regs_q[C_S_AXI_DATA_WIDTH*g +: C_S_AXI_DATA_WIDTH] = regs[g];
  end

  // Read path
  rd_state_e                     rd_state_q, rd_state_d;
  logic                          arready, rvalid, ar_hs;
  logic [IDX_W-1:0]              ar_idx;
  logic                          rd_in_range;
  logic [C_S_AXI_DATA_WIDTH-1:0] rd_val;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
  logic [1:0]                    rresp_q;
  logic                          unused_prot_lsb;

  assign unused_prot_lsb = ^{s_axi.awprot, s_axi.arprot, s_axi.araddr[ADDR_LSB-1:0]};

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rd_state_q <= R_IDLE;
    end else begin
      rd_state_q <= rd_state_d;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    arready    = 1'b0;
    rvalid     = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        arready = live;
        if (s_axi.arvalid && live) begin
          rd_state_d = R_VALID;
        end
      end
      R_VALID: begin
        rvalid = 1'b1;
        if (s_axi.rready) begin
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  assign ar_hs       = s_axi.arvalid & arready;
  assign ar_idx      = s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
  assign rd_in_range = int'(ar_idx) < NUM_REGS;

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == IDX_W'(i)) begin
        rd_val = regs[i];
      end
    end
  end

  // Sampled from the register array before this edge's write lands, so a
  // read racing a commit to the same register returns the old value.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (ar_hs) begin
      rdata_q <= rd_in_range ? rd_val : '0;
      rresp_q <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
    end
  end

  assign s_axi.arready = arready;
  assign s_axi.rvalid  = rvalid;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
  assign rd_state_dbg  = rd_state_q;

endmodule
